fwd_ctrl: RTL and testbench

Operand-forwarding and load-use hazard controller for the 5-stage pipelined datapath. It produces the 2-bit select codes that steer the two EX-stage operand 3-to-1 muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result. It tracks destination registers down the pipeline and raises a stall on load-use hazards. It sits beside the ID/EX pipeline register and sees every instruction leaving ID.

---
 rtl/fwd_ctrl.sv | 148 ++++++++++++++
 tb/tb_fwd_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_ctrl
// Description : Operand-forwarding and load-use hazard controller for a
//               5-stage pipeline. Tracks destination registers from ID
//               through EX, MEM and WB. Produces registered EX operand-mux
//               selects (00 regfile, 01 EX/MEM, 10 MEM/WB). Raises a
//               combinational stall on load-use hazards.
// Ports       : clk, rst_n (async, active-low), hold (global freeze),
//               flush (kill ID instruction),
//               id_rs/id_rt/id_use_rs/id_use_rt (ID sources),
//               id_rd/id_regwrite/id_memread (ID destination info),
//               fwd_a_sel/fwd_b_sel (registered selects), stall (comb).
// Config      : FWD_LOAD_STALL_EN enables load-use detection and bubble
//               insertion. Without it, stall is tied 0 and load-ness is
//               not tracked (the compiler owns load-delay spacing).
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_ctrl #(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            flush,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall
);

    localparam logic [1:0] c_SEL_REGFILE = 2'b00;
    localparam logic [1:0] c_SEL_EXMEM   = 2'b01;
    localparam logic [1:0] c_SEL_MEMWB   = 2'b10;

    // Pipeline tracking state
    logic [REGW-1:0] ex_rd_q,  ex_rd_d;
    logic            ex_rw_q,  ex_rw_d;
    logic [REGW-1:0] mem_rd_q;
    logic            mem_rw_q;
    logic [REGW-1:0] wb_rd_q;
    logic            wb_rw_q;
    logic [1:0]      fwd_a_q,  fwd_a_d;
    logic [1:0]      fwd_b_q,  fwd_b_d;

    logic            w_bubble;
    logic            w_unused;

    // A source is forwarded only when read, nonzero, and matching a live
    // writer. The instruction now in EX is the newest producer, so it wins.
    function automatic logic [1:0] sel_for(
        input logic [REGW-1:0] src,
        input logic            used,
        input logic [REGW-1:0] exr,
        input logic            exw,
        input logic [REGW-1:0] memr,
        input logic            memw
    );
        logic [1:0] sel;
        sel = c_SEL_REGFILE;
        if (used && (src != '0)) begin
            if (exw && (src == exr))
                sel = c_SEL_EXMEM;
            else if (memw && (src == memr))
                sel = c_SEL_MEMWB;
        end
        return sel;
    endfunction

`ifdef FWD_LOAD_STALL_EN
    logic ex_ld_q, ex_ld_d;
    logic w_load_use;

    assign w_load_use = ex_ld_q && ex_rw_q && (ex_rd_q != '0) &&
                        ((id_use_rs && (id_rs == ex_rd_q)) ||
                         (id_use_rt && (id_rt == ex_rd_q)));
    // A flushed ID instruction is being discarded, so it cannot stall.
    assign stall    = w_load_use && !flush;
    assign w_bubble = flush || w_load_use;
`else
    assign stall    = 1'b0;
    assign w_bubble = flush;
`endif

    always_comb begin
        ex_rd_d = id_rd;
        ex_rw_d = id_regwrite;
        fwd_a_d = sel_for(id_rs, id_use_rs, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
        fwd_b_d = sel_for(id_rt, id_use_rt, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
`ifdef FWD_LOAD_STALL_EN
        ex_ld_d = id_memread;
`endif
        // A bubble neither writes nor consumes, so it carries no forwarding.
        if (w_bubble) begin
            ex_rd_d = '0;
            ex_rw_d = 1'b0;
            fwd_a_d = c_SEL_REGFILE;
            fwd_b_d = c_SEL_REGFILE;
`ifdef FWD_LOAD_STALL_EN
            ex_ld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
            fwd_a_q  <= c_SEL_REGFILE;
            fwd_b_q  <= c_SEL_REGFILE;
`ifdef FWD_LOAD_STALL_EN
            ex_ld_q  <= 1'b0;
`endif
        end else if (!hold) begin
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
`ifdef FWD_LOAD_STALL_EN
            ex_ld_q  <= ex_ld_d;
`endif
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

    // The register file writes through, so WB needs no forward path. The WB
    // tracking state is kept for visibility only. id_memread has no
    // consumer when load-use detection is compiled out.
    assign w_unused = ^{wb_rd_q, wb_rw_q, id_memread};

endmodule
`default_nettype wire

// File: tb/tb_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_ctrl
// Description : Directed self-checking bench for fwd_ctrl. Expected values
//               follow FWD_LOAD_STALL_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_ctrl;

    localparam int REGW = 5;

    logic            clk;
    logic            rst_n;
    logic            hold;
    logic            flush;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            stall;

    int errors = 0;
    int checks = 0;

    fwd_ctrl #(.REGW(REGW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input int rd, input bit rw, input bit ld);
        id_rs       = REGW'(rs);
        id_rt       = REGW'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rd       = REGW'(rd);
        id_regwrite = rw;
        id_memread  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            issue(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            id_rs       = REGW'($urandom);
            id_rt       = REGW'($urandom);
            id_rd       = REGW'($urandom);
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            id_regwrite = 1'($urandom);
            id_memread  = 1'($urandom);
            hold        = 1'($urandom);
            flush       = 1'($urandom);
            tick();
        end
        chk("reset_a", fwd_a_sel, 2'b00);
        chk("reset_b", fwd_b_sel, 2'b00);
        chk("reset_stall", {1'b0, stall}, 2'b00);
        hold  = 1'b0;
        flush = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // First instruction reads r8 on an empty pipeline
        issue(8, 8, 1, 1, 9, 1, 0);
        tick();
        chk("first_a", fwd_a_sel, 2'b00);
        chk("first_b", fwd_b_sel, 2'b00);
        nops(3);

        // add r8 ; sub r9,r8,r8
        issue(1, 2, 1, 1, 8, 1, 0);
        tick();
        issue(8, 8, 1, 1, 9, 1, 0);
        #1 chk("sub_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("exmem_a", fwd_a_sel, 2'b01);
        chk("exmem_b", fwd_b_sel, 2'b01);

        // Async reset mid-pipeline discards in-flight writers
        rst_n = 1'b0;
        #1 chk("midrst_a", fwd_a_sel, 2'b00);
        chk("midrst_b", fwd_b_sel, 2'b00);
        #2 rst_n = 1'b1;
        issue(8, 9, 1, 1, 3, 1, 0);
        tick();
        chk("postrst_a", fwd_a_sel, 2'b00);
        chk("postrst_b", fwd_b_sel, 2'b00);
        nops(3);

        // add r8 ; nop ; or r10,r8,r2
        issue(1, 2, 1, 1, 8, 1, 0);
        tick();
        nops(1);
        issue(8, 2, 1, 1, 10, 1, 0);
        tick();
        chk("memwb_a", fwd_a_sel, 2'b10);
        chk("memwb_b", fwd_b_sel, 2'b00);
        nops(3);

        // add r8 ; add r8 ; reader of r8 -> newest wins
        issue(1, 2, 1, 1, 8, 1, 0);
        tick();
        issue(3, 4, 1, 1, 8, 1, 0);
        tick();
        issue(8, 8, 1, 1, 11, 1, 0);
        tick();
        chk("newest_a", fwd_a_sel, 2'b01);
        chk("newest_b", fwd_b_sel, 2'b01);
        nops(3);

        // lw r8 ; add r9,r8,r1
        issue(2, 0, 1, 0, 8, 1, 1);
        tick();
        issue(8, 1, 1, 1, 9, 1, 0);
`ifdef FWD_LOAD_STALL_EN
        #1 chk("lu_stall", {1'b0, stall}, 2'b01);
        tick();
        chk("lu_bubble_a", fwd_a_sel, 2'b00);
        chk("lu_bubble_b", fwd_b_sel, 2'b00);
        chk("lu_stall_once", {1'b0, stall}, 2'b00);
        tick();
        chk("lu_retry_a", fwd_a_sel, 2'b10);
        chk("lu_retry_b", fwd_b_sel, 2'b00);
`else
        #1 chk("lu_nostall", {1'b0, stall}, 2'b00);
        tick();
        chk("lu_slot_a", fwd_a_sel, 2'b01);
        chk("lu_slot_b", fwd_b_sel, 2'b00);
`endif
        nops(3);

        // Writer to r0 never forwards
        issue(1, 2, 1, 1, 0, 1, 0);
        tick();
        issue(0, 0, 1, 1, 12, 1, 0);
        tick();
        chk("r0_a", fwd_a_sel, 2'b00);
        chk("r0_b", fwd_b_sel, 2'b00);
        nops(3);

        // Unused rt matching a writer is not forwarded
        issue(1, 2, 1, 1, 5, 1, 0);
        tick();
        issue(5, 5, 1, 0, 13, 1, 0);
        tick();
        chk("unused_rt_a", fwd_a_sel, 2'b01);
        chk("unused_rt_b", fwd_b_sel, 2'b00);
        nops(3);

        // Flush a load consumer: no stall, bubble in EX
        issue(2, 0, 1, 0, 8, 1, 1);
        tick();
        issue(8, 1, 1, 1, 9, 1, 0);
        flush = 1'b1;
        #1 chk("flush_stall", {1'b0, stall}, 2'b00);
        tick();
        flush = 1'b0;
        chk("flush_a", fwd_a_sel, 2'b00);
        chk("flush_b", fwd_b_sel, 2'b00);
        issue(9, 8, 1, 1, 14, 1, 0);
        #1 chk("flush_nostall", {1'b0, stall}, 2'b00);
        tick();
        chk("flush_bubble_a", fwd_a_sel, 2'b00);
        chk("flush_load_b", fwd_b_sel, 2'b10);
        nops(3);

        // Hold for 3 cycles mid-sequence
        issue(1, 2, 1, 1, 8, 1, 0);
        tick();
        issue(8, 8, 1, 1, 10, 1, 0);
        tick();
        chk("prehold_a", fwd_a_sel, 2'b01);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(3, 3, 1, 1, 3, 1, 0);
            tick();
            chk("hold_a", fwd_a_sel, 2'b01);
            chk("hold_b", fwd_b_sel, 2'b01);
        end
        hold = 1'b0;
        issue(8, 10, 1, 1, 15, 1, 0);
        tick();
        chk("posthold_a", fwd_a_sel, 2'b10);
        chk("posthold_b", fwd_b_sel, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
